// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: prefix codes, receiver
// state encoding and the scan codes consumed downstream by keyboard_input.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Set-1 codes are not used here; these are scan code set 2 make codes
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_B     = 8'h32;
    localparam logic [7:0] KEY_C     = 8'h21;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_E     = 8'h24;
    localparam logic [7:0] KEY_F     = 8'h2B;
    localparam logic [7:0] KEY_G     = 8'h34;
    localparam logic [7:0] KEY_H     = 8'h33;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_3     = 8'h26;
    localparam logic [7:0] KEY_4     = 8'h25;
    localparam logic [7:0] KEY_5     = 8'h2E;
    localparam logic [7:0] KEY_6     = 8'h36;
    localparam logic [7:0] KEY_7     = 8'h3D;
    localparam logic [7:0] KEY_8     = 8'h3E;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_K     = 8'h42;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    // Odd parity over data+parity and a high stop bit make a good frame
    function automatic logic frame_ok(input logic [7:0] data,
                                      input logic       parity,
                                      input logic       stop);
        return (^{data, parity}) & stop;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS/2 clock and data pins and produces a one-cycle pulse
// on each falling edge of the synchronised clock, with data aligned to it.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic dat_s,
    output logic clk_fall
);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] clk_sync_next;
    logic [SYNC_STAGES-1:0] dat_sync_reg;
    logic [SYNC_STAGES-1:0] dat_sync_next;
    logic                   clk_prev_reg;
    logic                   clk_fall_reg;
    logic                   dat_dly_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign clk_sync_next[gi] = ps2_clk;
                assign dat_sync_next[gi] = ps2_dat;
            end else begin : g_chain
                assign clk_sync_next[gi] = clk_sync_reg[gi-1];
                assign dat_sync_next[gi] = dat_sync_reg[gi-1];
            end
        end
    endgenerate

    // Bus idles high, so resetting to 1 avoids a phantom fall after reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_reg <= '1;
            dat_sync_reg <= '1;
            clk_prev_reg <= 1'b1;
            clk_fall_reg <= 1'b0;
            dat_dly_reg  <= 1'b1;
        end else begin
            clk_sync_reg <= clk_sync_next;
            dat_sync_reg <= dat_sync_next;
            clk_prev_reg <= clk_sync_reg[SYNC_STAGES-1];
            clk_fall_reg <= clk_prev_reg & ~clk_sync_reg[SYNC_STAGES-1];
            dat_dly_reg  <= dat_sync_reg[SYNC_STAGES-1];
        end
    end

    assign clk_fall = clk_fall_reg;
    assign dat_s    = dat_dly_reg;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host byte receiver with break/extended prefix tracking and a
// key-press strobe shaped for the rising-edge detector in keyboard_input.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int PULSE_CYCLES   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ps2_key_data,
    output logic       ps2_key_pressed,
    output logic [7:0] ps2_out,
    output logic       byte_valid,
    output logic       extended,
    output logic       rx_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PCW   = $clog2(PULSE_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PCW-1:0]   PULSE_TOP = PCW'(PULSE_CYCLES - 1);

    logic dat_s;
    logic clk_fall;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .dat_s   (dat_s),
        .clk_fall(clk_fall)
    );

    rx_state_t        state_reg,  state_next;
    logic [2:0]       bitcnt_reg, bitcnt_next;
    logic [7:0]       shift_reg,  shift_next;
    logic             parity_reg, parity_next;
    logic [TMO_W-1:0] tmo_reg,    tmo_next;
    logic             frame_end;
    logic             frame_good;
    logic             timeout;
    logic             is_prefix;
    logic             make_hit;

    logic [7:0]     key_data_reg;
    logic           pressed_reg;
    logic [7:0]     out_reg;
    logic           byte_valid_reg;
    logic           extended_reg;
    logic           rx_err_reg;
    logic           break_pend_reg;
    logic           ext_pend_reg;
    logic           strobe_start_reg;
    logic [PCW-1:0] pulse_cnt_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            bitcnt_reg <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tmo_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            bitcnt_reg <= bitcnt_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            tmo_reg    <= tmo_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        bitcnt_next = bitcnt_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        tmo_next    = tmo_reg;
        frame_end   = 1'b0;
        timeout     = 1'b0;

        // A fall in the expiry cycle takes priority, so the bit is kept
        if (state_reg == ST_IDLE || clk_fall) begin
            tmo_next = '0;
        end else if (tmo_reg == TMO_LAST) begin
            timeout    = 1'b1;
            state_next = ST_IDLE;
            tmo_next   = '0;
        end else begin
            tmo_next = tmo_reg + 1'b1;
        end

        if (clk_fall) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!dat_s) begin
                        state_next  = ST_DATA;
                        bitcnt_next = '0;
                    end
                end
                ST_DATA: begin
                    shift_next  = {dat_s, shift_reg[7:1]};
                    bitcnt_next = bitcnt_reg + 1'b1;
                    if (bitcnt_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_next = dat_s;
                    state_next  = ST_STOP;
                end
                ST_STOP: begin
                    frame_end  = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign frame_good = frame_ok(shift_reg, parity_reg, dat_s);
    assign is_prefix  = (shift_reg == SC_BREAK) || (shift_reg == SC_EXT);
    assign make_hit   = frame_end & frame_good & ~is_prefix & ~break_pend_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_data_reg     <= '0;
            out_reg          <= '0;
            byte_valid_reg   <= 1'b0;
            extended_reg     <= 1'b0;
            rx_err_reg       <= 1'b0;
            break_pend_reg   <= 1'b0;
            ext_pend_reg     <= 1'b0;
            strobe_start_reg <= 1'b0;
        end else begin
            byte_valid_reg   <= 1'b0;
            rx_err_reg       <= timeout;
            strobe_start_reg <= make_hit;
            if (frame_end) begin
                if (frame_good) begin
                    out_reg        <= shift_reg;
                    byte_valid_reg <= 1'b1;
                    if (shift_reg == SC_BREAK) begin
                        break_pend_reg <= 1'b1;
                    end else if (shift_reg == SC_EXT) begin
                        ext_pend_reg <= 1'b1;
                    end else begin
                        break_pend_reg <= 1'b0;
                        ext_pend_reg   <= 1'b0;
                        if (!break_pend_reg) begin
                            key_data_reg <= shift_reg;
                            extended_reg <= ext_pend_reg;
                        end
                    end
                end else begin
                    rx_err_reg <= 1'b1;
                end
            end
        end
    end

    // A new make always drops the strobe for a cycle so every make gets its own rising edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pressed_reg   <= 1'b0;
            pulse_cnt_reg <= '0;
        end else if (make_hit) begin
            pressed_reg   <= 1'b0;
            pulse_cnt_reg <= '0;
        end else if (strobe_start_reg) begin
            pressed_reg   <= 1'b1;
            pulse_cnt_reg <= PULSE_TOP;
        end else if (pulse_cnt_reg != '0) begin
            pulse_cnt_reg <= pulse_cnt_reg - 1'b1;
        end else begin
            pressed_reg <= 1'b0;
        end
    end

    assign ps2_key_data    = key_data_reg;
    assign ps2_key_pressed = pressed_reg;
    assign ps2_out         = out_reg;
    assign byte_valid      = byte_valid_reg;
    assign extended        = extended_reg;
    assign rx_err          = rx_err_reg;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: table of frames with expected results, a scoreboard
// fed at stimulus time and drained by an output monitor, plus timeout/reset sequences.
module tb_ps2_scancode_rx;

    localparam int PULSE = 2;
    localparam int TMO   = 5000;
    localparam int NV    = 17;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic [7:0] ps2_out;
    logic       byte_valid;
    logic       extended;
    logic       rx_err;

    ps2_scancode_rx #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TMO),
        .PULSE_CYCLES  (PULSE)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ps2_clk        (ps2_clk),
        .ps2_dat        (ps2_dat),
        .ps2_key_data   (ps2_key_data),
        .ps2_key_pressed(ps2_key_pressed),
        .ps2_out        (ps2_out),
        .byte_valid     (byte_valid),
        .extended       (extended),
        .rx_err         (rx_err)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic       err;
        logic [7:0] val;
    } ev_t;

    typedef struct {
        logic [7:0] key;
        logic       ext;
    } key_t;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic       exp_good;
        logic       exp_strobe;
        logic       exp_ext;
        logic [7:0] exp_key;
    } vec_t;

    ev_t  ev_q[$];
    key_t key_q[$];
    ev_t  ev_cur;
    key_t key_cur;
    int   bv_cyc = -100;
    int   hi_len = 0;
    logic pressed_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (byte_valid || rx_err) begin
                if (ev_q.size() == 0) begin
                    check("unexpected_event", ev_q.size(), 1);
                end else begin
                    ev_cur = ev_q.pop_front();
                    check("rx_err", rx_err, ev_cur.err);
                    check("byte_valid", byte_valid, !ev_cur.err);
                    if (!ev_cur.err) begin
                        check("ps2_out", ps2_out, ev_cur.val);
                        bv_cyc = cyc;
                    end
                end
            end
            if (ps2_key_pressed && !pressed_prev) begin
                if (key_q.size() == 0) begin
                    check("unexpected_strobe", key_q.size(), 1);
                end else begin
                    key_cur = key_q.pop_front();
                    check("key_data", ps2_key_data, key_cur.key);
                    check("extended", extended, key_cur.ext);
                    check("strobe_latency", cyc - bv_cyc, 1);
                end
                hi_len = 1;
            end else if (ps2_key_pressed) begin
                hi_len++;
            end else if (pressed_prev) begin
                check("strobe_width", hi_len, PULSE);
            end
            pressed_prev = ps2_key_pressed;
        end else begin
            pressed_prev = 1'b0;
            hi_len       = 0;
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (10) @(posedge clock);
        ps2_clk = 1'b0;
        repeat (20) @(posedge clock);
        ps2_clk = 1'b1;
        repeat (10) @(posedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~(^d) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_dat = 1'b1;
        repeat (30) @(posedge clock);
    endtask

    task automatic push_good(input logic [7:0] d);
        ev_t e;
        e.err = 1'b0;
        e.val = d;
        ev_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e.err = 1'b1;
        e.val = 8'h00;
        ev_q.push_back(e);
    endtask

    task automatic push_key(input logic [7:0] k, input logic x);
        key_t kk;
        kk.key = k;
        kk.ext = x;
        key_q.push_back(kk);
    endtask

    task automatic drain_check(input logic [7:0] exp_key, input logic exp_ext, input logic [7:0] exp_out);
        @(negedge clock);
        check("drain_events", ev_q.size(), 0);
        check("drain_keys", key_q.size(), 0);
        check("key_data_hold", ps2_key_data, exp_key);
        check("extended_hold", extended, exp_ext);
        check("ps2_out_hold", ps2_out, exp_out);
    endtask

    vec_t       vecs[NV];
    logic [7:0] last_out;
    logic       seen;
    int         t0;
    int         elapsed;

    initial begin
        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C};
        vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C};
        vecs[4]  = '{8'h74, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h74};
        vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h74};
        vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h74};
        vecs[7]  = '{8'h74, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h74};
        vecs[8]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};
        vecs[9]  = '{8'h16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C};
        vecs[10] = '{8'h16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1C};
        vecs[11] = '{8'h16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h16};
        vecs[12] = '{8'h16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h16};
        vecs[13] = '{8'h6B, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h6B};
        vecs[14] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h6B};
        vecs[15] = '{8'h32, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h6B};
        vecs[16] = '{8'h32, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h6B};

        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rst_key_data", ps2_key_data, 8'h00);
        check("rst_pressed", ps2_key_pressed, 1'b0);
        check("rst_out", ps2_out, 8'h00);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_extended", extended, 1'b0);
        check("rst_rx_err", rx_err, 1'b0);
        reset = 1'b1;
        repeat (10) @(posedge clock);

        last_out = 8'h00;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].exp_good) begin
                push_good(vecs[i].data);
                last_out = vecs[i].data;
            end else begin
                push_err();
            end
            if (vecs[i].exp_strobe) push_key(vecs[i].exp_key, vecs[i].exp_ext);
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
            $display("vec %0d byte %02h par_bad %0d stop_bad %0d -> out %02h key %02h ext %0d",
                     i, vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, ps2_out, ps2_key_data, extended);
            drain_check(vecs[i].exp_key, vecs[i].exp_ext, last_out);
        end

        // Partial frame then silence: the frame must be dropped with one rx_err
        push_err();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        t0      = cyc;
        seen    = 1'b0;
        elapsed = 0;
        for (int k = 0; k < TMO + 1000 && !seen; k++) begin
            @(negedge clock);
            if (rx_err) begin
                seen    = 1'b1;
                elapsed = cyc - t0;
            end
        end
        check("timeout_seen", seen, 1'b1);
        check("timeout_window", (elapsed >= TMO - 50 && elapsed <= TMO), 1'b1);
        $display("timeout partial frame -> rx_err after %0d cycles", elapsed);
        drain_check(8'h6B, 1'b0, last_out);

        push_good(8'h1E);
        push_key(8'h1E, 1'b0);
        send_frame(8'h1E, 1'b0, 1'b0);
        last_out = 8'h1E;
        $display("post-timeout byte 1E -> key %02h", ps2_key_data);
        drain_check(8'h1E, 1'b0, last_out);

        // Leave an E0 pending, then reset in the middle of the next frame
        push_good(8'hE0);
        send_frame(8'hE0, 1'b0, 1'b0);
        drain_check(8'h1E, 1'b0, 8'hE0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_key_data", ps2_key_data, 8'h00);
        check("midrst_out", ps2_out, 8'h00);
        check("midrst_pressed", ps2_key_pressed, 1'b0);
        check("midrst_byte_valid", byte_valid, 1'b0);
        check("midrst_extended", extended, 1'b0);
        check("midrst_rx_err", rx_err, 1'b0);
        repeat (5) @(posedge clock);
        reset = 1'b1;
        repeat (50) @(posedge clock);
        drain_check(8'h00, 1'b0, 8'h00);

        push_good(8'h2D);
        push_key(8'h2D, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b0);
        $display("post-reset byte 2D -> key %02h ext %0d", ps2_key_data, extended);
        drain_check(8'h2D, 1'b0, 8'h2D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
